// File: rtl/brick_field.sv
// brick_field: owns the row of six bricks the ball engine bounces off.
// Publishes fixed brick positions and the live presence mask, scans one
// brick per cycle for overlap with the ball, and retires a hit brick
// HIT_DELAY+1 cycles after detection so the ball engine still sees it
// while bouncing. Keeps a saturating score and flags a cleared field.
//
// Ports:
//   clk, rst (async, active-low)     clock / reset
//   start                             level, leaves IDLE when high
//   ball_x, ball_y                    ball top-left corner
//   ball_destroyed                    ball lost, freezes the field
//   brick1_x..brick6_x, brick*_y      constant brick positions
//   bricks_exist                      bit n-1 = brick n present
//   score                             bricks retired, saturating at 255
//   hit_pulse                         one-cycle strobe on retirement
//   all_cleared                       high while the field is cleared
//
// Optional feature: define BRICK_RESPAWN_EN to refill the field after
// RESPAWN_CYCLES cycles in CLEARED; otherwise CLEARED is terminal.
module brick_field #(
`ifdef BRICK_RESPAWN_EN
    parameter int unsigned RESPAWN_CYCLES = 50000000,
`endif
    parameter int unsigned BRICK_X0    = 140,
    parameter int unsigned BRICK_PITCH = 60,
    parameter int unsigned BRICK_Y     = 60,
    parameter int unsigned HIT_DELAY   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] ball_x,
    input  logic [8:0] ball_y,
    input  logic       ball_destroyed,
    output logic [8:0] brick1_x,
    output logic [8:0] brick2_x,
    output logic [8:0] brick3_x,
    output logic [8:0] brick4_x,
    output logic [8:0] brick5_x,
    output logic [8:0] brick6_x,
    output logic [8:0] brick1_y,
    output logic [8:0] brick2_y,
    output logic [8:0] brick3_y,
    output logic [8:0] brick4_y,
    output logic [8:0] brick5_y,
    output logic [8:0] brick6_y,
    output logic [5:0] bricks_exist,
    output logic [7:0] score,
    output logic       hit_pulse,
    output logic       all_cleared
);

    localparam int unsigned CW = $clog2(HIT_DELAY + 1);
`ifdef BRICK_RESPAWN_EN
    localparam int unsigned RW = $clog2(RESPAWN_CYCLES + 1);
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCAN    = 3'd1,
        PEND    = 3'd2,
        RETIRE  = 3'd3,
        CLEARED = 3'd4,
        FROZEN  = 3'd5
    } state_t;

    state_t          state;
    logic [2:0]      idx;
    logic [2:0]      pend_idx;
    logic [CW-1:0]   cnt;
`ifdef BRICK_RESPAWN_EN
    logic [RW-1:0]   rcnt;
`endif

    // Constant brick geometry
    assign brick1_x = 9'(BRICK_X0);
    assign brick2_x = 9'(BRICK_X0 + 1 * BRICK_PITCH);
    assign brick3_x = 9'(BRICK_X0 + 2 * BRICK_PITCH);
    assign brick4_x = 9'(BRICK_X0 + 3 * BRICK_PITCH);
    assign brick5_x = 9'(BRICK_X0 + 4 * BRICK_PITCH);
    assign brick6_x = 9'(BRICK_X0 + 5 * BRICK_PITCH);
    assign brick1_y = 9'(BRICK_Y);
    assign brick2_y = 9'(BRICK_Y);
    assign brick3_y = 9'(BRICK_Y);
    assign brick4_y = 9'(BRICK_Y);
    assign brick5_y = 9'(BRICK_Y);
    assign brick6_y = 9'(BRICK_Y);

    // Overlap test for the brick under the scan pointer, 10-bit so no sum wraps
    logic [9:0] bx;
    logic [9:0] by;
    logic [9:0] bxl;
    logic [9:0] byl;
    logic       hit_c;
    logic [5:0] mask_next_c;

    always_comb begin
        bx    = 10'(BRICK_X0 + 32'(idx) * BRICK_PITCH);
        by    = 10'(BRICK_Y);
        bxl   = {1'b0, ball_x};
        byl   = {1'b0, ball_y};
        hit_c = bricks_exist[idx]
             && (bxl <= bx + 10'd57) && (bxl + 10'd20 >= bx)
             && (byl <= by + 10'd19) && (byl + 10'd20 >= by);
        mask_next_c = bricks_exist & ~(6'd1 << pend_idx);
    end

    // Field state machine with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            idx          <= 3'd0;
            pend_idx     <= 3'd0;
            cnt          <= '0;
            bricks_exist <= 6'b111111;
            score        <= 8'd0;
            hit_pulse    <= 1'b0;
            all_cleared  <= 1'b0;
`ifdef BRICK_RESPAWN_EN
            rcnt         <= '0;
`endif
        end else begin
            hit_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SCAN;
                        idx   <= 3'd0;
                    end
                end
                SCAN: begin
                    if (hit_c) begin
                        pend_idx <= idx;
                        cnt      <= CW'(HIT_DELAY);
                        state    <= PEND;
                    end else if (ball_destroyed) begin
                        state <= FROZEN;
                    end else begin
                        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
                    end
                end
                PEND: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= RETIRE;
                    end
                end
                RETIRE: begin
                    bricks_exist <= mask_next_c;
                    hit_pulse    <= 1'b1;
                    if (score != 8'hff) begin
                        score <= score + 8'd1;
                    end
                    if (mask_next_c == 6'd0) begin
                        state       <= CLEARED;
                        all_cleared <= 1'b1;
                    end else begin
                        state <= SCAN;
                        idx   <= (pend_idx == 3'd5) ? 3'd0 : pend_idx + 3'd1;
                    end
                end
                CLEARED: begin
`ifdef BRICK_RESPAWN_EN
                    // Refill after the dwell; the score carries over
                    if (rcnt == RW'(RESPAWN_CYCLES - 1)) begin
                        rcnt         <= '0;
                        bricks_exist <= 6'b111111;
                        all_cleared  <= 1'b0;
                        state        <= SCAN;
                        idx          <= 3'd0;
                    end else begin
                        rcnt <= rcnt + RW'(1);
                    end
`endif
                end
                FROZEN: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
